trng_source: RTL and testbench
==============================

// Module: trng_source
// PURPOSE
//  Responder end of the TRNG request/word/valid interface consumed by the rng core.
//  Collects raw entropy bits, removes bias with a Von Neumann corrector and packs the result into TRNG_WIDTH-bit words.
//  Buffers words in a small FIFO and returns one word per trng_req.
//  Sits between the entropy sampler and the rng core's TRNG_REQ/TRNG_WORD/TRNG_VALID pins.
// PARAMETERS
//  TRNG_WIDTH  4   bits per output word (>=2)
//  FIFO_DEPTH  4   buffered words; power of 2, >=2
//  RCT_LIMIT   32  repetition-count threshold; used only with TRNG_HEALTH_EN
// PORTS
//  clk          in   1                      single clock
//  resetn       in   1                      asynchronous reset, active-low
//  raw_bit      in   1                      raw entropy sample, already synchronised to clk
//  raw_valid    in   1                      raw_bit is valid this cycle
//  trng_req     in   1                      level request; requester holds it high until trng_valid
//  trng_word    out  TRNG_WIDTH             random word; meaningful while trng_valid is high
//  trng_valid   out  1                      one-cycle pulse delivering trng_word
//  fifo_level   out  $clog2(FIFO_DEPTH)+1   number of words buffered
//  health_fail  out  1                      sticky health-test failure flag
// BEHAVIOUR
//  Reset (async, resetn=0):
//   - trng_word=0, trng_valid=0, fifo_level=0, health_fail=0.
//   - Pair state EMPTY, bit count 0, shift register 0.
//   - trng_valid drops immediately, without waiting for a clock edge.
//  Debias FSM, advances only on raw_valid:
//   - EMPTY: store raw_bit, go to HAVE_FIRST.
//   - HAVE_FIRST: raw pair 10 emits 1; pair 01 emits 0; pairs 00/11 emit nothing. Always return to EMPTY.
//  Packing:
//   - Each emitted bit b updates sh <= {sh[W-2:0], b} and count <= count+1. The first bit ends up as the MSB.
//   - On the edge where count reaches W, the completed word {sh[W-2:0], b} is pushed and count resets to 0.
//   - The full check uses the pre-edge level. If the FIFO is full, the word is dropped even if a pop happens on the same edge.
//  Response (registered):
//   - At each edge, if trng_req=1, trng_valid=0 and the FIFO is non-empty (pre-edge): trng_valid<=1, trng_word<=head, pop.
//   - Otherwise trng_valid<=0; trng_word holds its last value.
//   - Latency is 1 cycle from a sampled req with a non-empty FIFO.
//   - Back-to-back pulses are at least 2 cycles apart. req held high yields a pulse every other cycle while words remain.
//   - Empty FIFO and push on the same edge: no pop on that edge; valid follows 1 cycle after the push edge.
//   - Push and pop on the same edge (non-empty, not full): both happen and fifo_level is unchanged.
//   - If req drops before valid, the request is withdrawn and no word is consumed.
//  FIFO: read/write pointers one bit wider than the address; wrap-around is natural modulo 2*FIFO_DEPTH.
// CONFIGURATION
//  TRNG_HEALTH_EN defined:
//   - A repetition counter tracks consecutive identical raw_bit values on raw_valid.
//   - When the counter reaches RCT_LIMIT: health_fail<=1 (sticky until reset), FIFO flushed, pair state and count cleared.
//   - After failure, no further pushes and trng_valid is never asserted.
//  TRNG_HEALTH_EN undefined:
//   - No counter is built; health_fail is tied to 0 and RCT_LIMIT is ignored.
// TESTING (W=4, FIFO_DEPTH=4, RCT_LIMIT=32)
//  1. Raw pairs 10,01,10,10 with req low -> fifo_level=1. Then req=1 -> trng_valid pulses 1 cycle later, trng_word=4'hB.
//  2. Pairs 00,11,10,00,01,11,10,10 -> 00/11 ignored, word 4'hB. Odd trailing raw bit -> no emission.
//  3. Five words fed with req low -> fifo_level=4, 5th dropped. Then req held 8 cycles -> 4 pulses on alternate cycles, FIFO order, level 0.
//  4. req=1 with FIFO empty, then one word completes -> trng_valid exactly 1 cycle after the push edge; level returns to 0.
//  5. resetn=0 asynchronously while trng_valid=1 and level=3 -> valid=0 before the next edge, level=0, word=0.
//  6. TRNG_HEALTH_EN: 32 consecutive raw 1s -> health_fail=1, level=0, held req gets no valid. Without the macro, health_fail stays 0.

Source files
------------

// File: rtl/trng_source.sv
// trng_source: Von Neumann-debiased entropy packer feeding a word FIFO and a req/valid responder.
// Build macro TRNG_HEALTH_EN adds a sticky repetition-count health test that flushes and locks the source.
module trng_source #(
  parameter int unsigned TRNG_WIDTH = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RCT_LIMIT  = 32
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        raw_bit,
  input  logic                        raw_valid,
  input  logic                        trng_req,
  output logic [TRNG_WIDTH-1:0]       trng_word,
  output logic                        trng_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        health_fail
);

  localparam int unsigned W  = TRNG_WIDTH;
  localparam int unsigned SW = TRNG_WIDTH - 1;
  localparam int unsigned CW = $clog2(TRNG_WIDTH);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic {
    PAIR_EMPTY,
    PAIR_HAVE_FIRST
  } pair_e;

  pair_e           pair_q;
  logic            first_q;
  logic [SW-1:0]   sh_q, sh_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   level_q, level_d;
  logic            valid_q, valid_d;
  logic [W-1:0]    word_q, word_d;
  logic [W-1:0]    mem [FIFO_DEPTH];

  logic            bit_vld_c;
  logic            last_bit_c;
  logic [W-1:0]    word_c;
  logic            empty_c;
  logic            full_c;
  logic            push_c;
  logic            wr_en_c;
  logic            pop_c;
  logic            flush_c;
  logic            block_c;

  // Only unequal raw pairs yield a bit, and the yielded bit is the first of the pair.
  assign bit_vld_c  = raw_valid && (pair_q == PAIR_HAVE_FIRST) && (first_q != raw_bit);
  assign last_bit_c = (cnt_q == CW'(W - 1));
  assign word_c     = {sh_q, first_q};

  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = ((wr_ptr_q ^ rd_ptr_q) == PW'(FIFO_DEPTH));
  assign push_c  = bit_vld_c && last_bit_c && !block_c;
  assign wr_en_c = push_c && !full_c;
  assign pop_c   = trng_req && !valid_q && !empty_c && !block_c;

`ifdef TRNG_HEALTH_EN
  localparam int unsigned RW = $clog2(RCT_LIMIT + 1);

  logic [RW-1:0] rct_cnt_q, rct_cnt_d;
  logic          rct_bit_q;
  logic          fail_q;
  logic          trip_c;

  // Run length of identical raw samples, saturating at the limit.
  always_comb begin
    rct_cnt_d = rct_cnt_q;
    if (raw_valid) begin
      if ((rct_cnt_q == '0) || (raw_bit != rct_bit_q)) begin
        rct_cnt_d = RW'(1);
      end else if (rct_cnt_q < RW'(RCT_LIMIT)) begin
        rct_cnt_d = RW'(rct_cnt_q + RW'(1));
      end
    end
  end

  assign trip_c = raw_valid && !fail_q && (rct_cnt_d == RW'(RCT_LIMIT));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rct_cnt_q <= '0;
      rct_bit_q <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      rct_cnt_q <= rct_cnt_d;
      if (raw_valid) rct_bit_q <= raw_bit;
      if (trip_c) fail_q <= 1'b1;
    end
  end

  assign flush_c     = trip_c;
  assign block_c     = trip_c | fail_q;
  assign health_fail = fail_q;
`else
  logic unused_rct;
  assign unused_rct  = ^32'(RCT_LIMIT);
  assign flush_c     = 1'b0;
  assign block_c     = 1'b0;
  assign health_fail = 1'b0;
`endif

  // Debias pair tracker.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pair_q  <= PAIR_EMPTY;
      first_q <= 1'b0;
    end else if (flush_c) begin
      pair_q  <= PAIR_EMPTY;
    end else if (raw_valid) begin
      case (pair_q)
        PAIR_EMPTY: begin
          first_q <= raw_bit;
          pair_q  <= PAIR_HAVE_FIRST;
        end
        default: pair_q <= PAIR_EMPTY;
      endcase
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    valid_d  = 1'b0;
    word_d   = word_q;
    if (bit_vld_c) begin
      sh_d  = SW'({sh_q, first_q});
      cnt_d = last_bit_c ? '0 : CW'(cnt_q + CW'(1));
    end
    if (wr_en_c) begin
      wr_ptr_d = PW'(wr_ptr_q + PW'(1));
    end
    // A pulse is never followed directly by another, so valid_q gates the pop.
    if (pop_c) begin
      rd_ptr_d = PW'(rd_ptr_q + PW'(1));
      valid_d  = 1'b1;
      word_d   = mem[rd_ptr_q[AW-1:0]];
    end
    case ({wr_en_c, pop_c})
      2'b10:   level_d = PW'(level_q + PW'(1));
      2'b01:   level_d = PW'(level_q - PW'(1));
      default: level_d = level_q;
    endcase
    if (flush_c) begin
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sh_q     <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      word_q   <= '0;
    end else begin
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      word_q   <= word_d;
    end
  end

  // Word storage carries no reset; contents are only read behind a valid write.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_ptr_q[AW-1:0]] <= word_c;
  end

  assign trng_word  = word_q;
  assign trng_valid = valid_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_trng_source.sv
// Directed bench for trng_source (W=4, depth 4, RCT limit 32); health checks follow TRNG_HEALTH_EN.
module tb_trng_source;

  localparam int unsigned W   = 4;
  localparam int unsigned D   = 4;
  localparam int unsigned RCT = 32;

  logic         clk       = 1'b0;
  logic         resetn    = 1'b0;
  logic         raw_bit   = 1'b0;
  logic         raw_valid = 1'b0;
  logic         trng_req  = 1'b0;
  logic [W-1:0] trng_word;
  logic         trng_valid;
  logic [2:0]   fifo_level;
  logic         health_fail;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  trng_source #(
    .TRNG_WIDTH (W),
    .FIFO_DEPTH (D),
    .RCT_LIMIT  (RCT)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .raw_bit     (raw_bit),
    .raw_valid   (raw_valid),
    .trng_req    (trng_req),
    .trng_word   (trng_word),
    .trng_valid  (trng_valid),
    .fifo_level  (fifo_level),
    .health_fail (health_fail)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic raw(input logic b);
    raw_bit   = b;
    raw_valid = 1'b1;
    @(posedge clk); #1;
    raw_valid = 1'b0;
  endtask

  task automatic pair(input logic a, input logic b);
    raw(a);
    raw(b);
  endtask

  task automatic emit(input logic b);
    if (b) pair(1'b1, 1'b0);
    else   pair(1'b0, 1'b1);
  endtask

  task automatic feed(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) emit(w[i]);
  endtask

  task automatic pop_one(input string tag, input logic [W-1:0] exp);
    trng_req = 1'b1;
    @(posedge clk); #1;
    check({tag, "_valid"}, 32'(trng_valid), 32'd1);
    check({tag, "_word"}, 32'(trng_word), 32'(exp));
    trng_req = 1'b0;
    @(posedge clk); #1;
    check({tag, "_gap"}, 32'(trng_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    #12;
    check("rst_word", 32'(trng_word), 32'd0);
    check("rst_valid", 32'(trng_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_health", 32'(health_fail), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    // 1: pairs 10,01,10,10 -> 1011
    pair(1, 0); pair(0, 1); pair(1, 0); pair(1, 0);
    check("t1_level", 32'(fifo_level), 32'd1);
    check("t1_novalid", 32'(trng_valid), 32'd0);
    pop_one("t1", 4'hB);
    check("t1_level_after", 32'(fifo_level), 32'd0);

    // 2: equal pairs ignored, trailing odd bit emits nothing
    pair(0, 0); pair(1, 1); pair(1, 0); pair(0, 0);
    pair(0, 1); pair(1, 1); pair(1, 0); pair(1, 0);
    check("t2_level", 32'(fifo_level), 32'd1);
    raw(1);
    check("t2_odd_level", 32'(fifo_level), 32'd1);
    raw(1);
    check("t2_11_level", 32'(fifo_level), 32'd1);
    pop_one("t2", 4'hB);

    // 3: fill to full, fifth word dropped, held req drains on alternate cycles
    feed(4'h1); feed(4'h2); feed(4'h3); feed(4'h4);
    check("t3_full", 32'(fifo_level), 32'd4);
    feed(4'h5);
    check("t3_drop", 32'(fifo_level), 32'd4);
    trng_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("t3_valid", 32'(trng_valid), 32'((i % 2) == 0));
      if ((i % 2) == 0) check("t3_word", 32'(trng_word), 32'(i / 2 + 1));
    end
    trng_req = 1'b0;
    check("t3_level", 32'(fifo_level), 32'd0);

    // 3b: full FIFO, push and pop on the same edge -> push still dropped
    feed(4'hA); feed(4'hB); feed(4'hC); feed(4'hD);
    emit(1); emit(1); emit(1);
    raw(0);
    trng_req = 1'b1;
    raw(1);
    check("t3b_valid", 32'(trng_valid), 32'd1);
    check("t3b_word", 32'(trng_word), 32'hA);
    check("t3b_level", 32'(fifo_level), 32'd3);
    trng_req = 1'b0;
    @(posedge clk); #1;
    pop_one("t3b_b", 4'hB);
    pop_one("t3b_c", 4'hC);
    pop_one("t3b_d", 4'hD);
    check("t3b_empty", 32'(fifo_level), 32'd0);

    // Push and pop on one edge with room: level unchanged
    feed(4'h1); feed(4'h2);
    emit(0); emit(0); emit(1);
    raw(1);
    trng_req = 1'b1;
    raw(0);
    check("pp_valid", 32'(trng_valid), 32'd1);
    check("pp_word", 32'(trng_word), 32'h1);
    check("pp_level", 32'(fifo_level), 32'd2);
    trng_req = 1'b0;
    @(posedge clk); #1;
    pop_one("pp_2", 4'h2);
    pop_one("pp_3", 4'h3);
    check("pp_empty", 32'(fifo_level), 32'd0);

    // 4: req waiting on empty FIFO; valid one cycle after the push edge
    trng_req = 1'b1;
    feed(4'h6);
    check("t4_push_valid", 32'(trng_valid), 32'd0);
    check("t4_push_level", 32'(fifo_level), 32'd1);
    @(posedge clk); #1;
    check("t4_valid", 32'(trng_valid), 32'd1);
    check("t4_word", 32'(trng_word), 32'h6);
    check("t4_level", 32'(fifo_level), 32'd0);
    trng_req = 1'b0;
    @(posedge clk); #1;

    // 5: asynchronous reset while valid is high
    feed(4'h7); feed(4'h8); feed(4'h9); feed(4'h5);
    trng_req = 1'b1;
    @(posedge clk); #1;
    check("t5_pre_valid", 32'(trng_valid), 32'd1);
    check("t5_pre_level", 32'(fifo_level), 32'd3);
    #2;
    resetn = 1'b0;
    #1;
    check("t5_valid", 32'(trng_valid), 32'd0);
    check("t5_level", 32'(fifo_level), 32'd0);
    check("t5_word", 32'(trng_word), 32'd0);
    trng_req = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    // 6: long run of ones
    feed(4'h5);
    for (int i = 0; i < int'(RCT); i++) raw(1);
`ifdef TRNG_HEALTH_EN
    check("t6_fail", 32'(health_fail), 32'd1);
    check("t6_level", 32'(fifo_level), 32'd0);
    trng_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("t6_novalid", 32'(trng_valid), 32'd0);
    end
    trng_req = 1'b0;
    feed(4'h3);
    check("t6_nopush", 32'(fifo_level), 32'd0);
    check("t6_sticky", 32'(health_fail), 32'd1);
`else
    check("t6_nofail", 32'(health_fail), 32'd0);
    check("t6_level", 32'(fifo_level), 32'd1);
    pop_one("t6", 4'h5);
    check("t6_nofail_end", 32'(health_fail), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
